// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg: shared definitions for the execute-stage multiply/divide unit.
//   - MD_WIDTH       : default operand / HI / LO width
//   - NO_MULT_DIV, MULT, DIV : HI/LO write-source encodings from the decoder
//   - md_state_e     : control FSM states (IDLE, MUL, DIV, FIX)
// ---------------------------------------------------------------------------
package md_pkg;

   localparam int MD_WIDTH = 32;

   localparam logic [1:0] NO_MULT_DIV = 2'b00;
   localparam logic [1:0] MULT        = 2'b01;
   localparam logic [1:0] DIV         = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_FIX  = 2'b11
   } md_state_e;

endpackage

// File: rtl/md_divider_core.sv
// ---------------------------------------------------------------------------
// md_divider_core: one radix-2 restoring division step on unsigned magnitudes.
//   rem_i     : partial remainder (always < divisor between steps)
//   quot_i    : shift register, holds remaining dividend bits in its top and
//               accumulated quotient bits in its bottom
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   quot_o    : quot_i shifted left with the new quotient bit appended
// Purely combinational.
// ---------------------------------------------------------------------------
module md_divider_core #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quot_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quot_o
);

   logic [WIDTH:0]   rem_shift_s;
   logic [WIDTH-1:0] diff_s;
   logic             fits_s;

   // The shifted remainder needs one extra bit; when the divisor fits, the true
   // difference is below the divisor, so the truncated subtraction is exact.
   assign rem_shift_s = {rem_i, quot_i[WIDTH-1]};
   assign fits_s      = (rem_shift_s >= {1'b0, divisor_i});
   assign diff_s      = rem_shift_s[WIDTH-1:0] - divisor_i;

   assign rem_o  = fits_s ? diff_s : rem_shift_s[WIDTH-1:0];
   assign quot_o = {quot_i[WIDTH-2:0], fits_s};

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit: execute-stage multiply/divide unit with architectural HI/LO.
//   clk, rst            : clock, asynchronous active-high reset
//   mult_en_e, div_en_e : start multiply / divide (multiply wins if both)
//   unsigned_instr_e    : unsigned operand interpretation
//   hi_write_e/lo_write_e, hi_src_e/lo_src_e : MTHI/MTLO-style direct writes
//   src_a_e, src_b_e    : rs / rt operands
//   hi_out, lo_out      : HI / LO registers
//   busy                : operation in flight (cycles 1..N after the start)
//   done                : one-cycle pulse after the final HI/LO update
// Multiply latency is MUL_CYCLES; divide is WIDTH restoring steps plus one
// sign-fixup cycle.
// ---------------------------------------------------------------------------
module mult_div_unit
   import md_pkg::*;
#(
   parameter int WIDTH      = MD_WIDTH,
   parameter int MUL_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mult_en_e,
   input  logic             div_en_e,
   input  logic             unsigned_instr_e,
   input  logic             hi_write_e,
   input  logic             lo_write_e,
   input  logic [1:0]       hi_src_e,
   input  logic [1:0]       lo_src_e,
   input  logic [WIDTH-1:0] src_a_e,
   input  logic [WIDTH-1:0] src_b_e,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2((WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES) + 1;

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   op_a_q, op_a_d;
   logic [WIDTH:0]   op_b_q, op_b_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic             neg_quot_q, neg_quot_d;
   logic             neg_rem_q, neg_rem_d;
   logic             div0_q, div0_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             neg_a_s, neg_b_s;
   logic [WIDTH-1:0] abs_a_s, abs_b_s;
   logic [2*WIDTH-1:0] mul_a_s, mul_b_s, mul_prod_s;
   logic [WIDTH-1:0] core_rem_s, core_quot_s;

   // Magnitudes for the divider; unsigned operands are taken as-is.
   assign neg_a_s = ~unsigned_instr_e & src_a_e[WIDTH-1];
   assign neg_b_s = ~unsigned_instr_e & src_b_e[WIDTH-1];
   assign abs_a_s = neg_a_s ? ({WIDTH{1'b0}} - src_a_e) : src_a_e;
   assign abs_b_s = neg_b_s ? ({WIDTH{1'b0}} - src_b_e) : src_b_e;

   // Operands were latched as WIDTH+1-bit signed values, so a modulo-2^(2W)
   // product of their sign extensions is correct for both MULT and MULTU.
   assign mul_a_s    = {{(WIDTH-1){op_a_q[WIDTH]}}, op_a_q};
   assign mul_b_s    = {{(WIDTH-1){op_b_q[WIDTH]}}, op_b_q};
   assign mul_prod_s = mul_a_s * mul_b_s;

   md_divider_core #(.WIDTH(WIDTH)) u_div_core (
      .rem_i     (rem_q),
      .quot_i    (quot_q),
      .divisor_i (op_b_q[WIDTH-1:0]),
      .rem_o     (core_rem_s),
      .quot_o    (core_quot_s)
   );

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      div0_d     = div0_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mult_en_e) begin
               op_a_d  = {~unsigned_instr_e & src_a_e[WIDTH-1], src_a_e};
               op_b_d  = {~unsigned_instr_e & src_b_e[WIDTH-1], src_b_e};
               cnt_d   = CNT_W'(MUL_CYCLES - 1);
               busy_d  = 1'b1;
               state_d = ST_MUL;
            end else if (div_en_e) begin
               op_a_d     = {1'b0, abs_a_s};
               op_b_d     = {1'b0, abs_b_s};
               rem_d      = {WIDTH{1'b0}};
               quot_d     = abs_a_s;
               neg_quot_d = neg_a_s ^ neg_b_s;
               neg_rem_d  = neg_a_s;
               div0_d     = (src_b_e == {WIDTH{1'b0}});
               cnt_d      = CNT_W'(WIDTH - 1);
               busy_d     = 1'b1;
               state_d    = ST_DIV;
            end else begin
               busy_d = 1'b0;
               if (hi_write_e && (hi_src_e == NO_MULT_DIV)) begin
                  hi_d = src_a_e;
               end else begin
                  hi_d = hi_q;
               end
               if (lo_write_e && (lo_src_e == NO_MULT_DIV)) begin
                  lo_d = src_a_e;
               end else begin
                  lo_d = lo_q;
               end
            end
         end

         ST_MUL: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               hi_d    = mul_prod_s[2*WIDTH-1:WIDTH];
               lo_d    = mul_prod_s[WIDTH-1:0];
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_DIV: begin
            rem_d  = core_rem_s;
            quot_d = core_quot_s;
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_FIX: begin
            if (div0_q) begin
               // Rebuild the original dividend from its magnitude and sign.
               lo_d = {WIDTH{1'b1}};
               hi_d = neg_rem_q ? ({WIDTH{1'b0}} - op_a_q[WIDTH-1:0]) : op_a_q[WIDTH-1:0];
            end else begin
               lo_d = neg_quot_q ? ({WIDTH{1'b0}} - quot_q) : quot_q;
               hi_d = neg_rem_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         op_a_q     <= {(WIDTH+1){1'b0}};
         op_b_q     <= {(WIDTH+1){1'b0}};
         rem_q      <= {WIDTH{1'b0}};
         quot_q     <= {WIDTH{1'b0}};
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         div0_q     <= 1'b0;
         hi_q       <= {WIDTH{1'b0}};
         lo_q       <= {WIDTH{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         div0_q     <= div0_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign hi_out = hi_q;
   assign lo_out = lo_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit: directed and randomized stimulus for mult_div_unit,
// checked every cycle against a latency-level reference model.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

   localparam int W  = 32;
   localparam int MC = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          mult_en_e, div_en_e, unsigned_instr_e;
   logic          hi_write_e, lo_write_e;
   logic [1:0]    hi_src_e, lo_src_e;
   logic [W-1:0]  src_a_e, src_b_e;
   logic [W-1:0]  hi_out, lo_out;
   logic          busy, done;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
      .clk              (clk),
      .rst              (rst),
      .mult_en_e        (mult_en_e),
      .div_en_e         (div_en_e),
      .unsigned_instr_e (unsigned_instr_e),
      .hi_write_e       (hi_write_e),
      .lo_write_e       (lo_write_e),
      .hi_src_e         (hi_src_e),
      .lo_src_e         (lo_src_e),
      .src_a_e          (src_a_e),
      .src_b_e          (src_b_e),
      .hi_out           (hi_out),
      .lo_out           (lo_out),
      .busy             (busy),
      .done             (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] ref_mul(input logic uns, input logic [31:0] a, input logic [31:0] b);
      longint pa, pb;
      pa = uns ? longint'({32'd0, a}) : longint'($signed(a));
      pb = uns ? longint'({32'd0, b}) : longint'($signed(b));
      return 64'(pa * pb);
   endfunction

   // Returns {HI, LO} = {remainder, quotient}.
   function automatic logic [63:0] ref_div(input logic uns, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (uns) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = $signed(a);
      sb = $signed(b);
      return {32'(sa % sb), 32'(sa / sb)};
   endfunction

   logic [31:0] m_hi, m_lo;
   logic        m_busy, m_done;
   logic [63:0] m_res;
   int          m_left;

   // Model: a started op yields its result after a fixed latency; in between,
   // every input is ignored.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0;
         m_res <= '0; m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_hi <= m_res[63:32]; m_lo <= m_res[31:0];
               m_busy <= 1'b0; m_done <= 1'b1;
            end
         end else if (mult_en_e) begin
            m_res <= ref_mul(unsigned_instr_e, src_a_e, src_b_e);
            m_left <= MC; m_busy <= 1'b1;
         end else if (div_en_e) begin
            m_res <= ref_div(unsigned_instr_e, src_a_e, src_b_e);
            m_left <= W + 1; m_busy <= 1'b1;
         end else begin
            if (hi_write_e && hi_src_e == 2'b00) m_hi <= src_a_e;
            if (lo_write_e && lo_src_e == 2'b00) m_lo <= src_a_e;
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      check("hi_out", hi_out, m_hi);
      check("lo_out", lo_out, m_lo);
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("done", {31'd0, done}, {31'd0, m_done});
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle_inputs();
      mult_en_e = 1'b0; div_en_e = 1'b0; unsigned_instr_e = 1'b0;
      hi_write_e = 1'b0; lo_write_e = 1'b0; hi_src_e = 2'b00; lo_src_e = 2'b00;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic run_op(input logic me, input logic de, input logic uns,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_lat, input bit inject, input string name);
      int cyc;
      cyc = 0;
      @(posedge clk); #1;
      idle_inputs();
      mult_en_e = me; div_en_e = de; unsigned_instr_e = uns;
      src_a_e = a; src_b_e = b;
      @(posedge clk); #1;
      mult_en_e = 1'b0; div_en_e = 1'b0;
      src_a_e = 32'hDEAD_BEEF; src_b_e = $urandom;
      for (int i = 1; i <= 100 && cyc == 0; i++) begin
         hi_write_e = inject && (i == 3);
         lo_write_e = inject && (i == 3);
         @(negedge clk);
         if (done) cyc = i;
         else begin
            @(posedge clk); #1;
         end
      end
      hi_write_e = 1'b0; lo_write_e = 1'b0;
      if (cyc == 0) begin
         n_checks++;
         $display("FAIL %s_timeout: done never seen within 100 cycles", name);
      end else begin
         check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
         check({name, "_hi"}, hi_out, exp_hi);
         check({name, "_lo"}, lo_out, exp_lo);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] saved_lo;
      int r;
      idle_inputs();
      src_a_e = '0; src_b_e = '0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_hi", hi_out, 32'd0);
      check("reset_lo", lo_out, 32'd0);
      check("reset_busy_done", {30'd0, busy, done}, 32'd0);
      rst = 1'b0;

      run_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MC + 1, 1'b0, "mult_neg");
      run_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MC + 1, 1'b0, "multu_max");
      run_op(1'b1, 1'b1, 1'b0, 32'd9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFEE, MC + 1, 1'b0, "both_en_mult_wins");
      run_op(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, W + 2, 1'b1, "div_neg_mtlo_busy");
      run_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, W + 2, 1'b0, "divu");
      run_op(1'b0, 1'b1, 1'b1, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, W + 2, 1'b0, "divu_by0");
      run_op(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, W + 2, 1'b0, "div_by0_neg");
      run_op(1'b0, 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, W + 2, 1'b0, "div_pos_neg");
      run_op(1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, W + 2, 1'b0, "div_ovf");

      // MTHI in IDLE: HI follows next cycle, LO holds, no done pulse.
      saved_lo = 32'h8000_0000;
      @(posedge clk); #1;
      hi_write_e = 1'b1; hi_src_e = 2'b00; src_a_e = 32'h1234_5678;
      @(posedge clk); #1;
      hi_write_e = 1'b0;
      @(negedge clk);
      check("mthi_hi", hi_out, 32'h1234_5678);
      check("mthi_lo", lo_out, saved_lo);
      check("mthi_no_done", {31'd0, done}, 32'd0);

      // Reset in the middle of a divide.
      @(posedge clk); #1;
      div_en_e = 1'b1; src_a_e = 32'd100; src_b_e = 32'd3;
      @(posedge clk); #1;
      div_en_e = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check("midrst_hi", hi_out, 32'd0);
      check("midrst_lo", lo_out, 32'd0);
      check("midrst_busy_done", {30'd0, busy, done}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_op(1'b1, 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, MC + 1, 1'b0, "mult_after_rst");

      // Randomized traffic, including starts and writes while busy.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         r = $urandom_range(0, 99);
         mult_en_e = (r < 8);
         div_en_e = (r >= 6 && r < 12);
         unsigned_instr_e = 1'($urandom_range(0, 1));
         hi_write_e = ($urandom_range(0, 3) == 0);
         lo_write_e = ($urandom_range(0, 3) == 0);
         hi_src_e = 2'($urandom_range(0, 3));
         lo_src_e = 2'($urandom_range(0, 3));
         src_a_e = pick();
         src_b_e = pick();
      end
      @(posedge clk); #1;
      idle_inputs();
      for (int i = 0; i < 60 && m_busy; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("final_idle", {31'd0, busy}, 32'd0);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
